// File: rtl/fetch_unit_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package fetch_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_DROP = 2'd1,
    S_OUT  = 2'd2
  } state_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues one imem request at a time and hands the
// word to decode over valid/ready; redirects may arrive at any point of a fetch.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            branch,
  input  logic            jump,
  input  logic [XLEN-1:0] target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr,
  output logic            misalign
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] drop_addr_q, drop_addr_d;
  logic            if_valid_q, if_valid_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic [XLEN-1:0] if_instr_q, if_instr_d;
  logic            misalign_q, misalign_d;

  logic            redirect;
  logic            bad_target;
  logic            redir_ok;
  logic            req_raw;

  always_comb begin
    redirect    = branch | jump;
    bad_target  = redirect & (target[1:0] != 2'b00);
    redir_ok    = redirect & ~bad_target;

    state_d     = state_q;
    pc_d        = pc_q;
    drop_addr_d = drop_addr_q;
    if_valid_d  = if_valid_q;
    if_pc_d     = if_pc_q;
    if_instr_d  = if_instr_q;
    misalign_d  = bad_target;
    req_raw     = 1'b0;
    imem_addr   = pc_q;

    case (state_q)
      S_REQ: begin
        req_raw = 1'b1;
        if (redir_ok) begin
          pc_d = target;
          // The bus request cannot be withdrawn, so remember its address until it completes.
          if (!imem_ack) begin
            state_d     = S_DROP;
            drop_addr_d = pc_q;
          end
        end else if (imem_ack) begin
          if_valid_d = 1'b1;
          if_pc_d    = pc_q;
          if_instr_d = imem_rdata;
          pc_d       = pc_q + 32'd4;
          state_d    = S_OUT;
        end
      end
      S_DROP: begin
        req_raw   = 1'b1;
        imem_addr = drop_addr_q;
        if (redir_ok) pc_d = target;
        if (imem_ack) state_d = S_REQ;
      end
      S_OUT: begin
        if (redir_ok || if_ready) begin
          if_valid_d = 1'b0;
          if_instr_d = NOP_INSTR;
          state_d    = S_REQ;
          if (redir_ok) pc_d = target;
        end
      end
      default: state_d = S_REQ;
    endcase

    imem_req = req_raw & ~rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      drop_addr_q <= RESET_PC;
      if_valid_q  <= 1'b0;
      if_pc_q     <= '0;
      if_instr_q  <= NOP_INSTR;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
      if_valid_q  <= if_valid_d;
      if_pc_q     <= if_pc_d;
      if_instr_q  <= if_instr_d;
      misalign_q  <= misalign_d;
    end
  end

  assign if_valid = if_valid_q;
  assign if_pc    = if_pc_q;
  assign if_instr = if_instr_q;
  assign misalign = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic, all checked every cycle
// against a transaction-level model of the fetch stage.
module tb_fetch_unit;

  localparam logic [31:0] KEY = 32'hA5A5_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, branch, jump, imem_ack, if_ready;
  logic [31:0] target, imem_rdata;
  logic        imem_req, if_valid, misalign;
  logic [31:0] imem_addr, if_pc, if_instr;

  logic        w_rst, w_ready, w_req, w_valid, w_mis;
  logic [31:0] w_addr, w_pc, w_instr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst(rst), .branch(branch), .jump(jump), .target(target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr),
    .misalign(misalign)
  );

  // Second instance exercises the PC wrap; its memory acks every request immediately.
  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(w_rst), .branch(1'b0), .jump(1'b0), .target(32'h0),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_req), .imem_rdata(w_addr ^ KEY),
    .if_valid(w_valid), .if_ready(w_ready), .if_pc(w_pc), .if_instr(w_instr),
    .misalign(w_mis)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: next fetch pc, a held instruction, and an in-flight stale request.
  bit          m_on = 0;
  logic [31:0] m_pc, m_hold_pc, m_hold_instr, m_stale_addr;
  bit          m_hold, m_stale, m_mis;

  always @(posedge clk) begin
    bit redir, ok;
    if (rst) begin
      m_on = 1; m_pc = 32'h0; m_hold = 0; m_stale = 0; m_mis = 0;
    end else if (m_on) begin
      redir = branch | jump;
      ok    = redir && (target[1:0] == 2'b00);
      m_mis = redir && !ok;
      if (m_hold) begin
        if (ok) begin m_hold = 0; m_pc = target; end
        else if (if_ready) m_hold = 0;
      end else if (m_stale) begin
        if (ok) m_pc = target;
        if (imem_ack) m_stale = 0;
      end else if (ok) begin
        if (!imem_ack) begin m_stale = 1; m_stale_addr = m_pc; end
        m_pc = target;
      end else if (imem_ack) begin
        m_hold = 1; m_hold_pc = m_pc; m_hold_instr = imem_rdata; m_pc = m_pc + 32'd4;
      end
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      chk("imem_req", imem_req, !m_hold && !rst);
      if (!m_hold && !rst) chk("imem_addr", imem_addr, m_stale ? m_stale_addr : m_pc);
      chk("if_valid", if_valid, m_hold);
      if (m_hold) begin
        chk("if_pc", if_pc, m_hold_pc);
        chk("if_instr", if_instr, m_hold_instr);
      end else chk("if_instr_nop", if_instr, NOP);
      if (if_valid) chk("instr_vs_pc", if_instr, if_pc ^ KEY);
      chk("misalign", misalign, m_mis);
    end
  end

  // Stimulus: memory acks a request after mem_delay cycles with rdata = addr ^ KEY.
  int          mem_cnt = 0, mem_delay = 0;
  bit          rand_delay = 0, spurious = 0;
  logic [31:0] handoffs[$];

  task automatic step(input logic r, input logic br, input logic jp,
                      input logic [31:0] tg, input logic rdy);
    rst = r; branch = br; jump = jp; target = tg; if_ready = rdy;
    imem_ack = 1'b0; imem_rdata = $urandom;
    #1;
    if (r) mem_cnt = 0;
    else if (imem_req) begin
      if (mem_cnt >= mem_delay) begin
        imem_ack = 1'b1; imem_rdata = imem_addr ^ KEY; mem_cnt = 0;
        if (rand_delay) mem_delay = $urandom_range(0, 3);
      end else mem_cnt++;
    end else if (spurious && $urandom_range(0, 7) == 0) imem_ack = 1'b1;
    if (!r && if_valid && rdy && !((br | jp) && tg[1:0] == 2'b00)) handoffs.push_back(if_pc);
    @(posedge clk); #2;
  endtask

  initial begin
    bit found;
    int n0;
    rst = 1; branch = 0; jump = 0; target = 0; imem_ack = 0; imem_rdata = 0; if_ready = 0;
    w_rst = 1; w_ready = 0;
    @(posedge clk); #2;
    step(1, 0, 0, 0, 0);
    w_rst = 0;
    chk("rst_req", imem_req, 0);
    chk("rst_valid", if_valid, 0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_instr", if_instr, NOP);
    chk("rst_mis", misalign, 0);

    // Straight-line fetch with a backpressure stall on pc 8.
    mem_delay = 1;
    step(1, 0, 0, 0, 1);
    handoffs.delete();
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (if_valid && if_pc == 32'h8) found = 1;
      else step(0, 0, 0, 0, 1);
    end
    chk("reach_pc8", found, 1);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 0);
      chk("bp_pc", if_pc, 32'h8);
      chk("bp_instr", if_instr, 32'h8 ^ KEY);
      chk("bp_req", imem_req, 0);
    end
    step(0, 0, 0, 0, 1);
    chk("bp_next_req", imem_req, 1);
    chk("bp_next_addr", imem_addr, 32'hC);
    for (int i = 0; i < 20 && handoffs.size() < 4; i++) step(0, 0, 0, 0, 1);
    chk("seq_count", handoffs.size() >= 4, 1);
    if (handoffs.size() >= 4) begin
      chk("seq0", handoffs[0], 32'h0);
      chk("seq1", handoffs[1], 32'h4);
      chk("seq2", handoffs[2], 32'h8);
      chk("seq3", handoffs[3], 32'hC);
    end

    // Redirect while the request is outstanding; ack arrives three cycles later.
    step(1, 0, 0, 0, 1);
    mem_delay = 3;
    step(0, 1, 0, 32'h100, 1);
    for (int i = 0; i < 3; i++) begin
      chk("drop_addr", imem_addr, 32'h0);
      chk("drop_valid", if_valid, 0);
      step(0, 0, 0, 0, 1);
    end
    chk("drop_valid_after", if_valid, 0);
    chk("drop_next_addr", imem_addr, 32'h100);

    // Reset while a stale request is pending.
    step(1, 0, 0, 0, 1);
    step(0, 1, 0, 32'h40, 1);
    step(1, 0, 0, 0, 1);
    rst = 0; #1;
    chk("rst_drop_valid", if_valid, 0);
    chk("rst_drop_req", imem_req, 1);
    chk("rst_drop_addr", imem_addr, 32'h0);

    // Jump coincident with ack, then jump while an instruction is held.
    mem_delay = 0;
    step(1, 0, 0, 0, 1);
    n0 = handoffs.size();
    step(0, 0, 1, 32'h200, 1);
    chk("jmp_ack_valid", if_valid, 0);
    chk("jmp_ack_addr", imem_addr, 32'h200);
    step(0, 0, 0, 0, 0);
    chk("jmp_valid", if_valid, 1);
    chk("jmp_pc", if_pc, 32'h200);
    step(0, 0, 1, 32'h300, 1);
    chk("squash_valid", if_valid, 0);
    chk("squash_addr", imem_addr, 32'h300);
    chk("squash_nohand", handoffs.size(), n0);

    // Misaligned target is ignored apart from the pulse.
    step(1, 0, 0, 0, 1);
    step(0, 1, 0, 32'h102, 0);
    chk("mis_pulse", misalign, 1);
    chk("mis_pc", if_pc, 32'h0);
    step(0, 0, 0, 0, 0);
    chk("mis_clear", misalign, 0);
    step(0, 0, 0, 0, 1);
    chk("mis_seq_addr", imem_addr, 32'h4);

    // PC wrap on the second instance.
    chk("wrap_valid", w_valid, 1);
    chk("wrap_pc", w_pc, 32'hFFFF_FFFC);
    chk("wrap_instr", w_instr, 32'hFFFF_FFFC ^ KEY);
    w_ready = 1;
    @(posedge clk); #2;
    w_ready = 0;
    chk("wrap_req", w_req, 1);
    chk("wrap_addr", w_addr, 32'h0);

    // Random traffic.
    rand_delay = 1; spurious = 1;
    for (int i = 0; i < 3000; i++) begin
      logic r, br, jp;
      logic [31:0] tg;
      r  = ($urandom_range(0, 99) == 0);
      br = ($urandom_range(0, 11) == 0);
      jp = ($urandom_range(0, 15) == 0);
      tg = {$urandom_range(0, 255), 2'b00};
      if ($urandom_range(0, 3) == 0) tg[1:0] = 2'($urandom_range(1, 3));
      step(r, br, jp, tg, $urandom_range(0, 3) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
